// File: rtl/piso_serializer_pkg.sv
// -----------------------------------------------------------------------------
// piso_serializer_pkg
//   Shared definitions for the parallel-in / serial-out transmitter:
//   FSM state encoding, the default word length (shared with the downstream
//   4-bit shift stage so both sides agree on word size), the gap counter
//   width and a helper for sizing the bit counter.
//   No ports (package).
// -----------------------------------------------------------------------------
package piso_serializer_pkg;

    // Word length shared with the downstream serial-in register stage.
    localparam int DEFAULT_WIDTH = 4;

    // Inter-word idle gap counter width (gap of 0..15 cycles).
    localparam int GAP_CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Bit-index counter width for a word of the given length (at least 1 bit).
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// -----------------------------------------------------------------------------
// piso_serializer_if
//   Bundles the word handshake (in_data/in_valid/in_ready) and the serial
//   link (ser_stall/ser_en/ser_out/ser_last) plus the busy status.
//   Modports:
//     master : word source / serial sink side (drives in_data, in_valid,
//              ser_stall; observes everything else)
//     slave  : the serializer itself
// -----------------------------------------------------------------------------
interface piso_serializer_if
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_stall;
    logic             ser_en;
    logic             ser_out;
    logic             ser_last;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        output ser_stall,
        input  in_ready,
        input  ser_en,
        input  ser_out,
        input  ser_last,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  ser_stall,
        output in_ready,
        output ser_en,
        output ser_out,
        output ser_last,
        output busy
    );

endinterface

// File: rtl/bit_counter.sv
// -----------------------------------------------------------------------------
// bit_counter
//   Parameterised up-counter with synchronous active-high reset, a
//   synchronous load-zero (clear), a count enable and a terminal-count flag.
//   clear has priority over en, so a reload on the terminal cycle starts the
//   next run from zero.
//   Ports:
//     clk   in  clock
//     reset in  synchronous active-high reset
//     clear in  load zero
//     en    in  increment
//     tc    out count == TC_VALUE
// -----------------------------------------------------------------------------
module bit_counter #(
    parameter int CNT_W    = 2,
    parameter int TC_VALUE = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count_q;

    // NOTE: registers are written with non-blocking (<=) so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign tc = (count_q == CNT_W'(TC_VALUE));

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Accepts a WIDTH-bit word over valid/ready and shifts it out LSB first,
//   one bit per enabled cycle, driving ser_en as the shift enable of the
//   downstream right-shifting register. After WIDTH enabled cycles the
//   downstream register holds the word. Downstream may pause via ser_stall
//   (seen one cycle late); IDLE_GAP forces idle cycles between words.
//   All outputs decode registered state only.
//   Ports:
//     clk   in  clock
//     reset in  synchronous active-high reset
//     bus   slave modport of piso_serializer_if (handshake + serial link)
// -----------------------------------------------------------------------------
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int IDLE_GAP = 0
) (
    input  logic               clk,
    input  logic               reset,
    piso_serializer_if.slave   bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t                 state_q, state_d;
    logic [GAP_CNT_W-1:0]   gcnt_q, gcnt_d;
    logic [WIDTH-1:0]       shreg_q;
    logic                   stall_q;

    logic                   cnt_tc;
    logic                   shift_en;
    logic                   last_bit;
    logic                   ready;
    logic                   accept;

    // Stall is registered so ser_en never depends combinationally on an input.
    assign shift_en = (state_q == S_SHIFT) && !stall_q;
    assign last_bit = shift_en && cnt_tc;
    // With no gap, the last-bit cycle doubles as the accept slot for the
    // next word, giving bubble-free back-to-back transfer.
    assign ready    = (state_q == S_IDLE) || (last_bit && (IDLE_GAP == 0));
    assign accept   = bus.in_valid && ready;

    bit_counter #(
        .CNT_W    (CNT_W),
        .TC_VALUE (WIDTH - 1)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .en    (shift_en),
        .tc    (cnt_tc)
    );

    // FSM state register and gap counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case can leave it unassigned and infer a latch.
        state_d = state_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    if (IDLE_GAP == 0) begin
                        state_d = accept ? S_SHIFT : S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        gcnt_d  = GAP_CNT_W'(IDLE_GAP - 1);
                    end
                end
            end
            S_GAP: begin
                if (gcnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q - GAP_CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Shift register and registered stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shift register is reset because ser_out decodes
            // shreg_q[0] directly and must read 0 out of reset.
            shreg_q <= '0;
            stall_q <= 1'b0;
        end else begin
            stall_q <= bus.ser_stall;
            if (accept) begin
                shreg_q <= bus.in_data;
            end else if (shift_en) begin
                shreg_q <= shreg_q >> 1;
            end
        end
    end

    assign bus.in_ready = ready;
    assign bus.ser_en   = shift_en;
    // Holds through a stall because the register only moves on shift_en.
    assign bus.ser_out  = shreg_q[0];
    assign bus.ser_last = last_bit;
    assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Self-checking bench. dut0 has IDLE_GAP=0, dut2 has IDLE_GAP=2. Words
//   sent to dut0 push their expected bits and expected word into queues;
//   a negedge monitor pops them as ser_en bits appear and feeds a 4-bit
//   right-shift model of the downstream register.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(4)) bus0 ();
    piso_serializer_if #(.WIDTH(4)) bus2 ();

    piso_serializer #(.WIDTH(4), .IDLE_GAP(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    piso_serializer #(.WIDTH(4), .IDLE_GAP(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit         exp_bits[$];
    logic [3:0] exp_words[$];
    logic [3:0] model_q    = '0;
    int         bit_idx    = 0;
    int         words_done = 0;
    int         run        = 0;
    int         max_run    = 0;
    int         start_cyc  = 0;
    int         last_span  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor + downstream 4-bit right-shift register model for dut0.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus0.ser_en === 1'b1) begin
                run++;
                if (run > max_run) max_run = run;
                if (bit_idx == 0) start_cyc = cyc;
                check("bits_pending", 32'(exp_bits.size() > 0), 1);
                if (exp_bits.size() > 0) check("ser_out", bus0.ser_out, exp_bits.pop_front());
                model_q = {bus0.ser_out, model_q[3:1]};
                bit_idx++;
                check("ser_last", bus0.ser_last, 32'(bit_idx == 4));
                if (bit_idx == 4) begin
                    last_span = cyc - start_cyc + 1;
                    words_done++;
                    bit_idx = 0;
                    check("words_pending", 32'(exp_words.size() > 0), 1);
                    if (exp_words.size() > 0) check("q_word", model_q, exp_words.pop_front());
                end
            end else begin
                run = 0;
                check("last_without_en", bus0.ser_last, 0);
            end
        end
    end

    // Call at posedge+1. Holds in_valid until in_ready is seen, then drops it
    // after the accepting edge.
    task automatic send(input int sel, input logic [3:0] data);
        bit ok = 1'b0;
        if (sel == 0) begin
            bus0.in_data = data; bus0.in_valid = 1'b1;
        end else begin
            bus2.in_data = data; bus2.in_valid = 1'b1;
        end
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (((sel == 0) ? bus0.in_ready : bus2.in_ready) === 1'b1) ok = 1'b1;
        end
        check("accept", 32'(ok), 1);
        if (ok && sel == 0) begin
            for (int b = 0; b < 4; b++) exp_bits.push_back(data[b]);
            exp_words.push_back(data);
        end
        @(posedge clk); #1;
        if (sel == 0) bus0.in_valid = 1'b0;
        else          bus2.in_valid = 1'b0;
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 100 && words_done < n; i++) @(negedge clk);
        #1;
        check("words_done", words_done, n);
    endtask

    task automatic wait_bit_idx(input int n);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk); #1;
            if (bit_idx == n) seen = 1'b1;
        end
        check("bit_idx_reached", 32'(seen), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cnt;
        int gap;
        bit seen;
        bit ok;

        reset = 1'b1;
        bus0.in_data = '0; bus0.in_valid = 1'b0; bus0.ser_stall = 1'b0;
        bus2.in_data = '0; bus2.in_valid = 1'b0; bus2.ser_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_in_ready", bus0.in_ready, 1);
        check("rst_ser_en",   bus0.ser_en,   0);
        check("rst_ser_out",  bus0.ser_out,  0);
        check("rst_ser_last", bus0.ser_last, 0);
        check("rst_busy",     bus0.busy,     0);

        // Single word 4'b1010: ser_en in the 4 cycles after acceptance.
        @(posedge clk); #1;
        send(0, 4'b1010);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("lat_en", bus0.ser_en, 1);
        end
        @(negedge clk);
        check("post_word_en",    bus0.ser_en,   0);
        check("post_word_busy",  bus0.busy,     0);
        check("post_word_ready", bus0.in_ready, 1);
        check("span_plain",      last_span,     4);

        // Back-to-back with in_valid held: 8 consecutive ser_en cycles.
        @(posedge clk); #1;
        base    = words_done;
        max_run = 0;
        send(0, 4'hA);
        send(0, 4'h3);
        wait_words(base + 2);
        check("b2b_run", max_run, 8);

        // Stall for 3 cycles after the 2nd bit: span 7.
        @(posedge clk); #1;
        base = words_done;
        send(0, 4'b0110);
        wait_bit_idx(2);
        @(posedge clk); #1 bus0.ser_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus0.ser_stall = 1'b0;
        wait_words(base + 1);
        check("span_stall", last_span, 7);

        // Reset mid-word: word discarded, then a fresh word works.
        @(posedge clk); #1;
        send(0, 4'hF);
        wait_bit_idx(2);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_bits.delete();
        exp_words.delete();
        bit_idx = 0;
        @(negedge clk);
        check("midrst_en",    bus0.ser_en,   0);
        check("midrst_busy",  bus0.busy,     0);
        check("midrst_ready", bus0.in_ready, 1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus0.ser_en === 1'b1) cnt++;
        end
        check("midrst_no_bits", cnt, 0);
        @(posedge clk); #1;
        base = words_done;
        send(0, 4'h5);
        wait_words(base + 1);

        // in_data changes while shifting: no effect on the word in flight.
        @(posedge clk); #1;
        base = words_done;
        send(0, 4'h1);
        bus0.in_data = 4'h8;
        wait_words(base + 1);

        // IDLE_GAP=2: exactly 2 idle cycles between ser_last and next accept.
        @(posedge clk); #1;
        send(2, 4'hC);
        bus2.in_data  = 4'h3;
        bus2.in_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus2.ser_last === 1'b1) seen = 1'b1;
        end
        check("gap_saw_last", 32'(seen), 1);
        check("gap_last_ready", bus2.in_ready, 0);
        gap = 0;
        ok  = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus2.in_ready === 1'b1) ok = 1'b1;
            else if (bus2.ser_en === 1'b0 && bus2.busy === 1'b1) gap++;
        end
        check("gap_ready_again", 32'(ok), 1);
        check("gap_len", gap, 2);
        @(posedge clk); #1 bus2.in_valid = 1'b0;
        @(negedge clk);
        check("gap_word2_en",   bus2.ser_en,  1);
        check("gap_word2_bit0", bus2.ser_out, 1);

        repeat (8) @(posedge clk);
        check("queues_empty", 32'(exp_bits.size() + exp_words.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
